dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of DataMemory.
- Requester 0 is the pipeline MEM stage. Requester 1 is the debug/loader port.
- Grants one access at a time and drives DataMemory's address/writeData/mode/memRead/memWrite from registers.
- Checks alignment, captures readData and returns a one-cycle ack with data/error to the winning requester.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MODE_W, 2, width of mode field; values are the ISA.v `MEM_BYTE / `MEM_HALF / `MEM_WORD encodings

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- r0_req  in  1  requester 0 access request, held until r0_ack
- r0_write  in  1  1=store, 0=load
- r0_addr  in  AW  byte address
- r0_wdata  in  DW  store data
- r0_mode  in  MODE_W  access size
- r0_ack  out  1  one-cycle completion pulse
- r0_err  out  1  valid with r0_ack; misaligned access
- r0_rdata  out  DW  valid with r0_ack; load data
- r1_req, r1_write, r1_addr, r1_wdata, r1_mode, r1_ack, r1_err, r1_rdata: same as r0_* for requester 1
- mem_address  out  AW  to DataMemory address
- mem_write_data  out  DW  to DataMemory writeData
- mem_mode  out  MODE_W  to DataMemory mode
- mem_read  out  1  to DataMemory memRead
- mem_write  out  1  to DataMemory memWrite
- mem_read_data  in  DW  from DataMemory readData (combinational read)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous, active-high.
- Reset values: state=IDLE, last_grant=1, all mem_* outputs 0, all acks/errs 0, all rdata 0, busy 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each access takes exactly 3 cycles. No pipelining.
- IDLE:
  - If any req is high at the edge, choose a winner and go to ACCESS.
  - Winner: the only requester asserting req. If both assert, the requester != last_grant wins (round-robin). last_grant updates to the winner.
  - At the same edge, register the winner's addr/wdata/mode into mem_address/mem_write_data/mem_mode and latch owner id.
  - Alignment check: misaligned if mode=`MEM_WORD and addr[1:0]!=0, or mode=`MEM_HALF and addr[0]!=0. `MEM_BYTE is never misaligned.
  - If aligned: mem_write=winner write, mem_read=~winner write. If misaligned: both strobes 0 and err flag latched.
- ACCESS (exactly one cycle):
  - Strobes are high for this cycle only. DataMemory commits a store at the edge ending ACCESS.
  - At that edge: rdata_reg = load and aligned ? mem_read_data : 0. Clear strobes. Go to RESP.
- RESP (exactly one cycle):
  - Owner's ack=1, err=latched flag, rdata=rdata_reg. The non-owner's ack/err stay 0.
  - Requests are not sampled in RESP.
  - At the edge ending RESP, ack/err clear, rdata holds its value, and state returns to IDLE.
- Requester rules:
  - Fields must be stable from req rise until the ack edge.
  - After ack, the requester either drops req or presents a new request. A still-high req in the following IDLE cycle is a new transaction.
  - req falling before ack is illegal; the arbiter completes the latched transaction anyway.
- Stores: rdata_reg = 0.
- Address, data and mode pass through unmodified. Byte/half lane handling is DataMemory's job.
- No starvation: with both requesting continuously, grants strictly alternate.
- Reset mid-operation:
  - Any state returns to IDLE on the reset edge, with no ack and strobes 0 from the next cycle.
  - A store whose ACCESS cycle ends on the reset edge is still committed by DataMemory (memory has no reset). The arbiter does not acknowledge it.
  - last_grant returns to 1, so the next tie goes to r0.
- Simultaneous req rise of both in IDLE directly after reset: r0 wins.

Test Plan:
- Write then read: r0 store `MEM_WORD 0xdead0000 @0x8 → mem_write high exactly 1 cycle with mem_address=8, r0_ack 3rd cycle after request edge, r0_err=0. Then r1 load `MEM_WORD @0x8 → r1_rdata=0xdead0000, r1_ack only (r0_ack stays 0).
- Fairness: both hold req for 4 transactions after reset, different addresses (0x0, 0x4, 0x10, 0x14) → grant order r0,r1,r0,r1; one ack per 3 cycles; busy drops for exactly one cycle between accesses.
- Misaligned: r0 `MEM_WORD load @0x12 → mem_read and mem_write never high, r0_ack with r0_err=1, r0_rdata=0. r1 `MEM_HALF @0x13 → err=1. `MEM_BYTE @0x13 → err=0 and memory is accessed.
- Store/load mix: r1 store `MEM_WORD 0x0000beef @0x10, then r0 load @0x10 → r0_rdata=0x0000beef. The store's ack carries rdata=0.
- Reset in ACCESS: assert reset for one edge while state=ACCESS on an r0 load → no r0_ack ever, mem_read=0 next cycle, busy=0. Then both req → r0 granted first.
- Idle hold: no req for 10 cycles → all strobes/acks 0, mem_* address/data hold last values, busy=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter/sequencer in front of DataMemory: round-robin grant,
// alignment check, registered memory strobes and a one-cycle ack back to the owner.
module dmem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MODE_W = 2,
  parameter logic [MODE_W-1:0] MODE_BYTE = MODE_W'(0),
  parameter logic [MODE_W-1:0] MODE_HALF = MODE_W'(1),
  parameter logic [MODE_W-1:0] MODE_WORD = MODE_W'(2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [AW-1:0]     r0_addr,
  input  logic [DW-1:0]     r0_wdata,
  input  logic [MODE_W-1:0] r0_mode,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DW-1:0]     r0_rdata,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [AW-1:0]     r1_addr,
  input  logic [DW-1:0]     r1_wdata,
  input  logic [MODE_W-1:0] r1_mode,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DW-1:0]     r1_rdata,
  output logic [AW-1:0]     mem_address,
  output logic [DW-1:0]     mem_write_data,
  output logic [MODE_W-1:0] mem_mode,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DW-1:0]     mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, stateNext;
  logic                lastGrant, owner, errFlag;
  logic                grantValid, winner;
  logic                winWrite, winMis;
  logic [AW-1:0]       winAddr;
  logic [DW-1:0]       winWdata;
  logic [MODE_W-1:0]   winMode;
  logic [DW-1:0]       accData;

  function automatic logic misAligned(input logic [MODE_W-1:0] m, input logic [1:0] a);
    return ((m == MODE_WORD) && (a != 2'b00)) || ((m == MODE_HALF) && a[0]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    grantValid = 1'b0;
    winner     = 1'b0;
    case (state)
      IDLE: if (r0_req || r1_req) begin
        grantValid = 1'b1;
        stateNext  = ACCESS;
        // on a tie the requester that did not win last time goes first
        winner     = (r0_req && r1_req) ? ~lastGrant : r1_req;
      end
      ACCESS:  stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    winAddr  = winner ? r1_addr  : r0_addr;
    winWdata = winner ? r1_wdata : r0_wdata;
    winMode  = winner ? r1_mode  : r0_mode;
    winWrite = winner ? r1_write : r0_write;
    winMis   = misAligned(winMode, winAddr[1:0]);
  end

  // mem_read is only ever set for an aligned load, so it doubles as the capture qualifier
  assign accData = mem_read ? mem_read_data : '0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant      <= 1'b1;
      owner          <= 1'b0;
      errFlag        <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_mode       <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      r0_ack         <= 1'b0;
      r0_err         <= 1'b0;
      r0_rdata       <= '0;
      r1_ack         <= 1'b0;
      r1_err         <= 1'b0;
      r1_rdata       <= '0;
    end else begin
      case (state)
        IDLE: if (grantValid) begin
          lastGrant      <= winner;
          owner          <= winner;
          mem_address    <= winAddr;
          mem_write_data <= winWdata;
          mem_mode       <= winMode;
          errFlag        <= winMis;
          mem_write      <= winWrite & ~winMis;
          mem_read       <= ~winWrite & ~winMis;
        end
        ACCESS: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          if (owner) begin
            r1_ack   <= 1'b1;
            r1_err   <= errFlag;
            r1_rdata <= accData;
          end else begin
            r0_ack   <= 1'b1;
            r0_err   <= errFlag;
            r0_rdata <= accData;
          end
        end
        RESP: begin
          r0_ack <= 1'b0;
          r0_err <= 1'b0;
          r1_ack <= 1'b0;
          r1_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word-addressed DataMemory model.
module tb_dmem_port_arbiter;

  localparam logic [1:0] MB = 2'd0, MH = 2'd1, MW = 2'd2;

  logic        clk, reset;
  logic        r0_req, r0_write, r1_req, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [1:0]  r0_mode, r1_mode;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [1:0]  mem_mode;
  logic        mem_read, mem_write, busy;

  int nChecks = 0;
  int nFail   = 0;

  dmem_port_arbiter #(.AW(32), .DW(32), .MODE_W(2),
    .MODE_BYTE(MB), .MODE_HALF(MH), .MODE_WORD(MW)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_mode(r0_mode), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_mode(r1_mode), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_mode(mem_mode),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // DataMemory stand-in: word array, combinational read, store on the rising edge
  logic        memInit;
  logic [31:0] memArr [0:63];
  assign mem_read_data = memArr[mem_address[7:2]];
  always @(posedge clk) begin
    if (memInit) for (int i = 0; i < 64; i++) memArr[i] <= 32'h1000 + i;
    else if (mem_write) memArr[mem_address[7:2]] <= mem_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one isolated access from requester id, checked cycle by cycle
  task automatic doAccess(input int id, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] mode,
                          input logic expErr, input logic [31:0] expRdata, input string tag);
    if (id == 0) begin
      r0_req = 1'b1; r0_write = wr; r0_addr = addr; r0_wdata = wdata; r0_mode = mode;
    end else begin
      r1_req = 1'b1; r1_write = wr; r1_addr = addr; r1_wdata = wdata; r1_mode = mode;
    end
    tick();
    check({tag, ".addr"},  mem_address, addr);
    check({tag, ".rdStb"}, 32'(mem_read),  32'(!wr && !expErr));
    check({tag, ".wrStb"}, 32'(mem_write), 32'(wr && !expErr));
    check({tag, ".busy"},  32'(busy), 32'd1);
    tick();
    check({tag, ".strobesOff"}, 32'({mem_read, mem_write}), 32'd0);
    check({tag, ".ack"},   32'(id == 0 ? r0_ack : r1_ack), 32'd1);
    check({tag, ".otherAck"}, 32'(id == 0 ? r1_ack : r0_ack), 32'd0);
    check({tag, ".err"},   32'(id == 0 ? r0_err : r1_err), 32'(expErr));
    check({tag, ".rdata"}, id == 0 ? r0_rdata : r1_rdata, expRdata);
    r0_req = 1'b0;
    r1_req = 1'b0;
    tick();
    check({tag, ".ackClr"}, 32'({r0_ack, r1_ack}), 32'd0);
    check({tag, ".idle"},   32'(busy), 32'd0);
  endtask

  logic [31:0] fAddr [4];
  logic [31:0] fData [4];

  initial begin
    reset = 1'b1; memInit = 1'b1;
    r0_req = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0; r0_mode = 0;
    r1_req = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0; r1_mode = 0;
    tick();
    tick();
    memInit = 1'b0;
    reset = 1'b0;

    check("rst.busy",  32'(busy), 32'd0);
    check("rst.strb",  32'({mem_read, mem_write}), 32'd0);
    check("rst.addr",  mem_address, 32'd0);
    check("rst.wdata", mem_write_data, 32'd0);
    check("rst.mode",  32'(mem_mode), 32'd0);
    check("rst.acks",  32'({r0_ack, r0_err, r1_ack, r1_err}), 32'd0);
    check("rst.r0rd",  r0_rdata, 32'd0);
    check("rst.r1rd",  r1_rdata, 32'd0);

    doAccess(0, 1'b1, 32'h8,  32'hdead0000, MW, 1'b0, 32'h0,        "wrWord");
    doAccess(1, 1'b0, 32'h8,  32'h0,        MW, 1'b0, 32'hdead0000, "rdWord");
    doAccess(0, 1'b0, 32'h12, 32'h0,        MW, 1'b1, 32'h0,        "misWord");
    doAccess(1, 1'b0, 32'h13, 32'h0,        MH, 1'b1, 32'h0,        "misHalf");
    doAccess(1, 1'b0, 32'h13, 32'h0,        MB, 1'b0, 32'h1004,     "byteOk");
    doAccess(1, 1'b1, 32'h10, 32'h0000beef, MW, 1'b0, 32'h0,        "r1Store");
    doAccess(0, 1'b0, 32'h10, 32'h0,        MW, 1'b0, 32'h0000beef, "r0Load");

    // fairness: tie after reset goes to r0, then strict alternation
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fAddr = '{32'h0, 32'h4, 32'h10, 32'h14};
    fData = '{32'h1000, 32'h1001, 32'h0000beef, 32'h1005};
    r0_write = 0; r1_write = 0; r0_mode = MW; r1_mode = MW;
    r0_addr = 32'h0; r1_addr = 32'h4;
    r0_req = 1; r1_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fair.addr", mem_address, fAddr[i]);
      check("fair.busy", 32'(busy), 32'd1);
      tick();
      check("fair.r0ack", 32'(r0_ack), 32'(i % 2 == 0));
      check("fair.r1ack", 32'(r1_ack), 32'(i % 2 == 1));
      check("fair.rdata", (i % 2 == 0) ? r0_rdata : r1_rdata, fData[i]);
      if (i == 0) r0_addr = 32'h10;
      if (i == 1) r1_addr = 32'h14;
      if (i == 2) r0_req = 1'b0;
      if (i == 3) r1_req = 1'b0;
      tick();
      check("fair.gap", 32'(busy), 32'd0);
    end

    // reset lands on the edge ending ACCESS of an r0 load
    r0_req = 1; r0_write = 0; r0_addr = 32'h8; r0_wdata = 32'h55; r0_mode = MW;
    tick();
    check("rstAcc.rdStb", 32'(mem_read), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstAcc.strb", 32'({mem_read, mem_write}), 32'd0);
    check("rstAcc.busy", 32'(busy), 32'd0);
    check("rstAcc.noAck", 32'({r0_ack, r1_ack}), 32'd0);
    r1_req = 1; r1_write = 0; r1_addr = 32'h4; r1_mode = MW;
    tick();
    check("rstAcc.r0first", mem_address, 32'h8);
    check("rstAcc.wdata", mem_write_data, 32'h55);
    tick();
    check("rstAcc.r0ack", 32'({r0_ack, r1_ack}), 32'b10);
    check("rstAcc.rdata", r0_rdata, 32'hdead0000);
    r0_req = 0; r1_req = 0;
    tick();

    // idle hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle.ctl", 32'({mem_read, mem_write, r0_ack, r1_ack, busy}), 32'd0);
      check("idle.addr", mem_address, 32'h8);
      check("idle.wdata", mem_write_data, 32'h55);
      check("idle.r0rd", r0_rdata, 32'hdead0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
